// File: rtl/capture_sequencer_if.sv
// Capture sequencer bus: control, decoder inputs and readout.
// The slave side belongs to the sequencer, the master side to its driver.
interface capture_sequencer_if #(
  parameter int NCH   = 2,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic             arm;
  logic             stop;
  logic             trig_any;
  logic [7:0]       trig_value;
  logic [NCH*8-1:0] ch_data;
  logic [NCH-1:0]   ch_valid;
  logic             detect_only;
  logic             rd_en;
  logic [7:0]       rd_data;
  logic [1:0]       rd_ch;
  logic             rd_valid;
  logic [AW:0]      count;
  logic [1:0]       state;
  logic             overflow;

  modport master (
    output arm, stop, trig_any, trig_value,
    output ch_data, ch_valid, rd_en,
    input  detect_only, rd_data, rd_ch,
    input  rd_valid, count, state, overflow
  );

  modport slave (
    input  arm, stop, trig_any, trig_value,
    input  ch_data, ch_valid, rd_en,
    output detect_only, rd_data, rd_ch,
    output rd_valid, count, state, overflow
  );
endinterface

// File: rtl/capture_sequencer.sv
// Arms NCH byte decoders, waits for a trigger byte and merges
// decoded bytes round-robin into a circular capture buffer.
module capture_sequencer #(
  parameter int NCH   = 2,
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  capture_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    CAPT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [NCH-1:0] pend_q, pend_d;
  logic [7:0]     pdat_q [NCH];
  logic [7:0]     pdat_d [NCH];
  logic [CW-1:0]  rr_q, rr_d;
  logic [AW-1:0]  wp_q, wp_d;
  logic [AW-1:0]  rp_q, rp_d;
  logic [AW:0]    cnt_q, cnt_d;
  logic [7:0]     rd_data_q, rd_data_d;
  logic [1:0]     rd_ch_q, rd_ch_d;
  logic           rd_valid_q, rd_valid_d;
  logic           ovf_q, ovf_d;
  logic           det_q, det_d;

  logic [7:0]     mem_data [DEPTH];
  logic [1:0]     mem_ch [DEPTH];

  logic           trig_hit;
  logic           cap_en;
  logic           gnt_vld;
  logic [CW-1:0]  gnt_idx;
  logic [CW-1:0]  scan;
  logic           we;
  logic           pop;
  logic           gnt_i;

  always_comb begin
    trig_hit = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (bus.ch_valid[i] &&
          (bus.trig_any ||
           bus.ch_data[8*i +: 8] == bus.trig_value))
        trig_hit = 1'b1;
    end
  end

  // first pending channel at or after the round-robin pointer
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    scan    = '0;
    for (int k = 0; k < NCH; k++) begin
      scan = CW'((int'(rr_q) + k) % NCH);
      if (!gnt_vld && pend_q[scan]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan;
      end
    end
  end

  assign we  = (state_q == CAPT) && gnt_vld;
  assign pop = (state_q == DONE) && bus.rd_en &&
               (cnt_q != '0) && !bus.arm;
  assign cap_en = (state_q == CAPT) ||
                  (state_q == ARMED && trig_hit);

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    pdat_d     = pdat_q;
    rr_d       = rr_q;
    wp_d       = wp_q;
    rp_d       = rp_q;
    cnt_d      = cnt_q;
    rd_data_d  = rd_data_q;
    rd_ch_d    = rd_ch_q;
    rd_valid_d = 1'b0;
    ovf_d      = ovf_q;
    gnt_i      = 1'b0;

    if (bus.arm) begin
      state_d = ARMED;
    end else begin
      case (state_q)
        ARMED: begin
          if (bus.stop)    state_d = DONE;
          else if (trig_hit) state_d = CAPT;
        end
        CAPT: begin
          if (bus.stop || (we && cnt_q == LAST))
            state_d = DONE;
        end
        default: state_d = state_q;
      endcase
    end

    for (int i = 0; i < NCH; i++) begin
      gnt_i = we && (gnt_idx == CW'(i));
      if (gnt_i) pend_d[i] = 1'b0;
      if (cap_en && bus.ch_valid[i]) begin
        if (pend_q[i] && !gnt_i) begin
          ovf_d = 1'b1;
        end else begin
          pend_d[i] = 1'b1;
          pdat_d[i] = bus.ch_data[8*i +: 8];
        end
      end
    end

    if (we) begin
      wp_d  = wp_q + 1'b1;
      cnt_d = cnt_q + 1'b1;
      rr_d  = CW'((int'(gnt_idx) + 1) % NCH);
    end

    if (pop) begin
      rp_d       = rp_q + 1'b1;
      cnt_d      = cnt_q - 1'b1;
      rd_valid_d = 1'b1;
      rd_data_d  = mem_data[rp_q];
      rd_ch_d    = mem_ch[rp_q];
    end

    // bytes still queued when capture ends are dropped silently
    if (state_d == DONE) pend_d = '0;

    if (bus.arm) begin
      pend_d = '0;
      ovf_d  = 1'b0;
      rr_d   = '0;
      wp_d   = '0;
      rp_d   = '0;
      cnt_d  = '0;
    end

    det_d = (state_d == IDLE) || (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      for (int i = 0; i < NCH; i++)
        pdat_q[i] <= '0;
      rr_q       <= '0;
      wp_q       <= '0;
      rp_q       <= '0;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_ch_q    <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      det_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      pdat_q     <= pdat_d;
      rr_q       <= rr_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_ch_q    <= rd_ch_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      det_q      <= det_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem_data[wp_q] <= pdat_q[gnt_idx];
      mem_ch[wp_q]   <= 2'(gnt_idx);
    end
  end

  assign bus.state       = state_q;
  assign bus.count       = cnt_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.rd_ch       = rd_ch_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.overflow    = ovf_q;
  assign bus.detect_only = det_q;
endmodule
